// File: rtl/snake_pkg.sv
// Shared types and constants for the snake head motion controller.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    LEFT  = 2'b01,
    DOWN  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10
  } state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int GRID_COLS = 26;
  localparam int GRID_ROWS = 20;
  localparam int HEAD_HALF = 12;
  localparam int START_COL = 13;
  localparam int START_ROW = 10;

  function automatic logic is_dir_key(input logic [7:0] k);
    return (k == KEY_W) || (k == KEY_A) || (k == KEY_S) || (k == KEY_D);
  endfunction

  function automatic dir_t key_dir(input logic [7:0] k);
    dir_t d;
    d = UP;
    case (k)
      KEY_A:   d = LEFT;
      KEY_S:   d = DOWN;
      KEY_D:   d = RIGHT;
      default: d = UP;
    endcase
    return d;
  endfunction

  // Opposite headings differ only in bit 1 with this encoding.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'({~d[1], d[0]});
  endfunction

endpackage

// File: rtl/snake_motion_ctrl_frame_tick_gen.sv
// Brings the asynchronous vsync level into the Clk domain and emits a
// single-cycle pulse on each rising edge.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign frame_tick = sync2_q & ~prev_q;

endmodule

// File: rtl/snake_motion_ctrl.sv
// Snake head motion controller: keyboard-driven FSM, frame-tick move
// divider and wrapping grid position with registered pixel outputs.
module snake_motion_ctrl
  import snake_pkg::*;
#(
  parameter int MOVE_DIV = 8,
  parameter int STEP     = 24
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] snakeX_pos,
  output logic [9:0] snakeY_pos,
  output logic [9:0] snake_size,
  output logic [1:0] direction,
  output logic       step_pulse,
  output logic       running
);

  logic       frame_tick;
  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  dir_t       pend_q, pend_d;
  logic [5:0] cnt_q, cnt_d;
  logic [4:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [9:0] xpos_q, xpos_d;
  logic [9:0] ypos_q, ypos_d;
  logic       step_q, step_d;
  logic [7:0] key_prev_q, key_prev_d;

  logic key_press, dir_key, space_key, move;
  dir_t new_dir;

  frame_tick_gen u_tick (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  always_comb begin
    key_press = (keycode != key_prev_q) && (keycode != 8'h00);
    dir_key   = key_press && is_dir_key(keycode);
    space_key = key_press && (keycode == KEY_SPACE);
    new_dir   = key_dir(keycode);
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    step_d     = 1'b0;
    key_prev_d = keycode;
    move       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = 6'd0;
        if (dir_key) begin
          state_d = S_RUN;
          dir_d   = new_dir;
          pend_d  = new_dir;
        end
      end
      S_RUN: begin
        if (space_key) state_d = S_PAUSED;
        if (frame_tick) begin
          if (cnt_q == 6'(MOVE_DIV - 1)) begin
            cnt_d = 6'd0;
            move  = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_PAUSED: begin
        if (space_key) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    // The move consumes the pending heading registered before this cycle.
    if (move) begin
      dir_d  = pend_q;
      step_d = 1'b1;
      case (pend_q)
        UP:    row_d = (row_q == 5'd0) ? 5'(GRID_ROWS - 1) : row_q - 5'd1;
        DOWN:  row_d = (row_q == 5'(GRID_ROWS - 1)) ? 5'd0 : row_q + 5'd1;
        LEFT:  col_d = (col_q == 5'd0) ? 5'(GRID_COLS - 1) : col_q - 5'd1;
        RIGHT: col_d = (col_q == 5'(GRID_COLS - 1)) ? 5'd0 : col_q + 5'd1;
      endcase
    end

    // Reversal check is against the heading in effect after this cycle.
    if ((state_q != S_IDLE) && dir_key && (new_dir != opposite(dir_d)))
      pend_d = new_dir;

    xpos_d = 10'(HEAD_HALF + STEP * int'(col_d));
    ypos_d = 10'(HEAD_HALF + STEP * int'(row_d));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      dir_q      <= UP;
      pend_q     <= UP;
      cnt_q      <= 6'd0;
      col_q      <= 5'(START_COL);
      row_q      <= 5'(START_ROW);
      xpos_q     <= 10'(HEAD_HALF + STEP * START_COL);
      ypos_q     <= 10'(HEAD_HALF + STEP * START_ROW);
      step_q     <= 1'b0;
      key_prev_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      step_q     <= step_d;
      key_prev_q <= key_prev_d;
    end
  end

  assign snakeX_pos = xpos_q;
  assign snakeY_pos = ypos_q;
  assign snake_size = 10'(HEAD_HALF);
  assign direction  = dir_q;
  assign step_pulse = step_q;
  assign running    = (state_q == S_RUN);

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Directed bench for snake_motion_ctrl with hand-computed expected positions.
module tb_snake_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] snakeX_pos, snakeY_pos, snake_size;
  logic [1:0] direction;
  logic       step_pulse, running;

  int total = 0;
  int passed = 0;
  int step_cnt = 0;

  snake_motion_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .snakeX_pos (snakeX_pos),
    .snakeY_pos (snakeY_pos),
    .snake_size (snake_size),
    .direction  (direction),
    .step_pulse (step_pulse),
    .running    (running)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    #1;
    if (step_pulse) step_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      cyc(3);
      frame_clk = 1'b0;
      cyc(3);
    end
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    cyc(2);
    keycode = 8'h00;
    cyc(2);
  endtask

  task automatic test_reset;
    Reset = 1'b1; keycode = 8'h00; frame_clk = 1'b0;
    cyc(3);
    total++; if (snakeX_pos !== 10'd324) $display("FAIL reset_x: got %0d want 324", snakeX_pos); else passed++;
    total++; if (snakeY_pos !== 10'd252) $display("FAIL reset_y: got %0d want 252", snakeY_pos); else passed++;
    total++; if (direction !== 2'd0) $display("FAIL reset_dir: got %0d want 0", direction); else passed++;
    total++; if (step_pulse !== 1'b0) $display("FAIL reset_step: got %0b want 0", step_pulse); else passed++;
    total++; if (running !== 1'b0) $display("FAIL reset_run: got %0b want 0", running); else passed++;
    total++; if (snake_size !== 10'd12) $display("FAIL size: got %0d want 12", snake_size); else passed++;
    Reset = 1'b0;
    cyc(1);
    press(8'h2C);
    total++; if (running !== 1'b0) $display("FAIL idle_space: got %0b want 0", running); else passed++;
  endtask

  task automatic test_start;
    int s0;
    s0 = step_cnt;
    press(8'h07);
    total++; if (running !== 1'b1) $display("FAIL start_run: got %0b want 1", running); else passed++;
    total++; if (direction !== 2'd3) $display("FAIL start_dir: got %0d want 3", direction); else passed++;
    pulses(7);
    total++; if (step_cnt !== s0) $display("FAIL start_early_step: got %0d want %0d", step_cnt, s0); else passed++;
    total++; if (snakeX_pos !== 10'd324) $display("FAIL start_early_x: got %0d want 324", snakeX_pos); else passed++;
    pulses(1);
    total++; if (step_cnt !== s0 + 1) $display("FAIL start_step: got %0d want %0d", step_cnt, s0 + 1); else passed++;
    total++; if (snakeX_pos !== 10'd348) $display("FAIL start_x: got %0d want 348", snakeX_pos); else passed++;
    total++; if (snakeY_pos !== 10'd252) $display("FAIL start_y: got %0d want 252", snakeY_pos); else passed++;
  endtask

  task automatic test_opposite;
    press(8'h04);
    pulses(8);
    total++; if (direction !== 2'd3) $display("FAIL opp_dir: got %0d want 3", direction); else passed++;
    total++; if (snakeX_pos !== 10'd372) $display("FAIL opp_x: got %0d want 372", snakeX_pos); else passed++;
    press(8'h1A);
    press(8'h04);
    pulses(8);
    total++; if (direction !== 2'd0) $display("FAIL last_dir: got %0d want 0", direction); else passed++;
    total++; if (snakeY_pos !== 10'd228) $display("FAIL last_y: got %0d want 228", snakeY_pos); else passed++;
    total++; if (snakeX_pos !== 10'd372) $display("FAIL last_x: got %0d want 372", snakeX_pos); else passed++;
  endtask

  task automatic test_wrap;
    pulses(72);
    total++; if (snakeY_pos !== 10'd12) $display("FAIL row0_y: got %0d want 12", snakeY_pos); else passed++;
    pulses(8);
    total++; if (snakeY_pos !== 10'd468) $display("FAIL wrap_up_y: got %0d want 468", snakeY_pos); else passed++;
    press(8'h07);
    pulses(80);
    total++; if (snakeX_pos !== 10'd612) $display("FAIL col25_x: got %0d want 612", snakeX_pos); else passed++;
    pulses(8);
    total++; if (snakeX_pos !== 10'd12) $display("FAIL wrap_right_x: got %0d want 12", snakeX_pos); else passed++;
    total++; if (direction !== 2'd3) $display("FAIL wrap_dir: got %0d want 3", direction); else passed++;
  endtask

  task automatic test_pause;
    int s;
    pulses(3);
    s = step_cnt;
    press(8'h2C);
    total++; if (running !== 1'b0) $display("FAIL pause_run: got %0b want 0", running); else passed++;
    pulses(20);
    total++; if (step_cnt !== s) $display("FAIL pause_step: got %0d want %0d", step_cnt, s); else passed++;
    total++; if (snakeX_pos !== 10'd12) $display("FAIL pause_x: got %0d want 12", snakeX_pos); else passed++;
    press(8'h2C);
    total++; if (running !== 1'b1) $display("FAIL resume_run: got %0b want 1", running); else passed++;
    pulses(4);
    total++; if (step_cnt !== s) $display("FAIL resume_early: got %0d want %0d", step_cnt, s); else passed++;
    pulses(1);
    total++; if (step_cnt !== s + 1) $display("FAIL resume_step: got %0d want %0d", step_cnt, s + 1); else passed++;
    total++; if (snakeX_pos !== 10'd36) $display("FAIL resume_x: got %0d want 36", snakeX_pos); else passed++;
  endtask

  task automatic test_reset_in_step;
    bit found;
    found = 1'b0;
    pulses(7);
    frame_clk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (step_pulse) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) $display("FAIL rst_step_seen: got %0b want 1", found); else passed++;
    total++; if (snakeX_pos !== 10'd60) $display("FAIL rst_step_x: got %0d want 60", snakeX_pos); else passed++;
    Reset = 1'b1;
    frame_clk = 1'b0;
    cyc(1);
    total++; if (snakeX_pos !== 10'd324) $display("FAIL rst_mid_x: got %0d want 324", snakeX_pos); else passed++;
    total++; if (snakeY_pos !== 10'd252) $display("FAIL rst_mid_y: got %0d want 252", snakeY_pos); else passed++;
    total++; if (running !== 1'b0) $display("FAIL rst_mid_run: got %0b want 0", running); else passed++;
    total++; if (step_pulse !== 1'b0) $display("FAIL rst_mid_step: got %0b want 0", step_pulse); else passed++;
    total++; if (direction !== 2'd0) $display("FAIL rst_mid_dir: got %0d want 0", direction); else passed++;
    cyc(2);
    Reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_hold_key;
    int   rises;
    logic prev;
    rises = 0;
    prev  = running;
    keycode = 8'h1A;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (running && !prev) rises++;
      prev = running;
    end
    total++; if (rises !== 1) $display("FAIL hold_rises: got %0d want 1", rises); else passed++;
    total++; if (running !== 1'b1) $display("FAIL hold_run: got %0b want 1", running); else passed++;
    total++; if (direction !== 2'd0) $display("FAIL hold_dir: got %0d want 0", direction); else passed++;
    keycode = 8'h00;
    cyc(2);
    total++; if (snakeY_pos !== 10'd252) $display("FAIL hold_y: got %0d want 252", snakeY_pos); else passed++;
  endtask

  task automatic test_ignored;
    press(8'h05);
    press(8'h2D);
    press(8'h16);
    press(8'hFF);
    total++; if (running !== 1'b1) $display("FAIL ign_run: got %0b want 1", running); else passed++;
    pulses(8);
    total++; if (snakeY_pos !== 10'd228) $display("FAIL ign_y: got %0d want 228", snakeY_pos); else passed++;
    total++; if (snakeX_pos !== 10'd324) $display("FAIL ign_x: got %0d want 324", snakeX_pos); else passed++;
    total++; if (direction !== 2'd0) $display("FAIL ign_dir: got %0d want 0", direction); else passed++;
  endtask

  task automatic test_same_cycle;
    pulses(7);
    frame_clk = 1'b1;
    cyc(2);
    keycode = 8'h07;
    cyc(1);
    total++; if (direction !== 2'd0) $display("FAIL same_dir: got %0d want 0", direction); else passed++;
    total++; if (snakeY_pos !== 10'd204) $display("FAIL same_y: got %0d want 204", snakeY_pos); else passed++;
    total++; if (snakeX_pos !== 10'd324) $display("FAIL same_x: got %0d want 324", snakeX_pos); else passed++;
    keycode = 8'h00;
    frame_clk = 1'b0;
    cyc(3);
    pulses(8);
    total++; if (direction !== 2'd3) $display("FAIL next_dir: got %0d want 3", direction); else passed++;
    total++; if (snakeX_pos !== 10'd348) $display("FAIL next_x: got %0d want 348", snakeX_pos); else passed++;
    total++; if (snakeY_pos !== 10'd204) $display("FAIL next_y: got %0d want 204", snakeY_pos); else passed++;
  endtask

  initial begin
    Reset = 1'b1;
    frame_clk = 1'b0;
    keycode = 8'h00;
    test_reset;
    test_start;
    test_opposite;
    test_wrap;
    test_pause;
    test_reset_in_step;
    test_hold_key;
    test_ignored;
    test_same_cycle;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/snake_motion_ctrl.md
SNAKE_MOTION_CTRL -- requirements
Module: snake_motion_ctrl

Interface
REQ-001 Parameter MOVE_DIV, default 8: number of frame ticks between head moves, legal range 1..63.
REQ-002 Parameter STEP, default 24: head move distance in pixels, equal to one grid cell.
REQ-003 Port Clk, input, 1 bit: the only clock.
REQ-004 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port frame_clk, input, 1 bit: VGA vsync level; its rising edge marks one frame tick.
REQ-006 Port keycode, input, 8 bits: current USB keycode; 0x00 means no key.
REQ-007 Port snakeX_pos, output, 10 bits: head centre X in pixels.
REQ-008 Port snakeY_pos, output, 10 bits: head centre Y in pixels.
REQ-009 Port snake_size, output, 10 bits: head half-size, constant 12.
REQ-010 Port direction, output, 2 bits: current heading; 00 = up (W), 01 = left (A), 10 = down (S), 11 = right (D).
REQ-011 Port step_pulse, output, 1 bit: one-Clk pulse in the cycle the head position changes.
REQ-012 Port running, output, 1 bit: 1 only in state RUN.

Function
REQ-013 frame_clk shall pass through a 2-flop synchroniser followed by a rising-edge detector, giving a 1-cycle frame_tick.
REQ-014 Key-press event: keycode differs from its value registered one cycle earlier, and the new value is non-zero.
REQ-015 Position shall be held as col (0..25) and row (0..19).
- snakeX_pos = 12 + STEP*col
- snakeY_pos = 12 + STEP*row
- Both outputs registered, no combinational path from inputs.
REQ-016 FSM states:
- IDLE -> RUN on a W/A/S/D press; direction is loaded immediately.
- RUN -> PAUSED on a space (0x2C) press.
- PAUSED -> RUN on a space press.
- A space press in IDLE is ignored.
REQ-017 In RUN, a 6-bit tick counter increments on each frame_tick.
- When the count reaches MOVE_DIV-1, the counter clears to 0.
- In that same cycle the head moves one cell in direction and step_pulse is asserted.
REQ-018 Wrap-around:
- col 25 moving right -> col 0; col 0 moving left -> col 25.
- row 19 moving down -> row 0; row 0 moving up -> row 19.
REQ-019 In RUN or PAUSED, a direction key press shall be stored as pending_dir. pending_dir is copied to direction at the next move, in the same cycle as the position update, and the move uses the new direction.
REQ-020 A pending key opposite to the current direction (W/S, A/D) shall be discarded; pending_dir keeps its previous value.
REQ-021 A later valid key press before the move shall overwrite pending_dir (last key wins).
REQ-022 In PAUSED:
- the counter freezes
- frame_tick is ignored
- position and direction hold.
REQ-023 Any keycode other than 0x1A, 0x04, 0x16, 0x07 or 0x2C shall have no effect.
REQ-024 If a frame_tick and a key press occur in the same cycle, the move uses the already-registered pending_dir. The new key takes effect at the following move.
REQ-025 In IDLE, the counter is held at 0 and step_pulse is 0.

Reset
REQ-026 On Reset:
- state = IDLE, col = 13, row = 10 (snakeX_pos = 324, snakeY_pos = 252)
- direction = pending_dir = 00
- counter = 0, step_pulse = 0, running = 0
- synchroniser and keycode history registers cleared.
REQ-027 Reset asserted mid-operation, including in the step cycle, shall take priority over every other update in that cycle.

Structure
REQ-028 A shared package snake_pkg shall hold:
- the dir_t enum (UP = 00, LEFT = 01, DOWN = 10, RIGHT = 11)
- the keycode constants KEY_W / KEY_A / KEY_S / KEY_D / KEY_SPACE
- GRID_COLS = 26, GRID_ROWS = 20, HEAD_HALF = 12.
REQ-029 The synchroniser and edge detector shall be one sub-module, frame_tick_gen.
REQ-030 The FSM, counter and position logic shall stay inside snake_motion_ctrl.

Verification
REQ-031 Reset, then press 0x07, then 8 frame_clk pulses -> direction = 11, one step_pulse, snakeX_pos = 348, snakeY_pos = 252.
REQ-032 Place the head at col 25 heading right, then one move -> col 0, snakeX_pos = 12.
- Same check heading up from row 0 -> snakeY_pos = 468.
REQ-033 Heading right, press 0x04 then wait 8 ticks -> direction stays 11 and X advances by 24.
- Then press 0x1A, 0x04 before the next move -> direction = 01 is rejected, 0x1A is kept, Y decreases by 24.
REQ-034 In RUN, press 0x2C, give 20 ticks, press 0x2C again -> no step_pulse while paused; the counter resumes from its frozen value.
REQ-035 Assert Reset in the step_pulse cycle -> next cycle X = 324, Y = 252, state IDLE, step_pulse = 0.
REQ-036 Hold keycode 0x1A for 100 cycles in IDLE -> exactly one press event and one transition to RUN.
